// File: rtl/pzcorebus_axi_rw_command_arbiter.sv
// Merges AXI read/write command streams onto one corebus command channel using weighted phase arbitration and outstanding limits.
// Latency: a grant in cycle N presents the command in cycle N+1. Backpressure: the single output register stalls all grants until i_cmd_accept.
// Optional starvation timers are built in when PZCOREBUS_RW_ARBITER_STARVATION_EN is defined.
module pzcorebus_axi_rw_command_arbiter #(
    parameter int ID_WIDTH      = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LENGTH_WIDTH  = 8,
    parameter int READ_WEIGHT   = 4,
    parameter int WRITE_WEIGHT  = 2,
    parameter int MAX_READS     = 8,
    parameter int MAX_WRITES    = 8,
    parameter int STARVE_CYCLES = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_rd_valid,
    output logic                                  o_rd_ready,
    input  logic [ID_WIDTH-1:0]                   i_rd_id,
    input  logic [ADDRESS_WIDTH-1:0]              i_rd_addr,
    input  logic [LENGTH_WIDTH-1:0]               i_rd_length,
    input  logic                                  i_wr_valid,
    output logic                                  o_wr_ready,
    input  logic [ID_WIDTH-1:0]                   i_wr_id,
    input  logic [ADDRESS_WIDTH-1:0]              i_wr_addr,
    input  logic [LENGTH_WIDTH-1:0]               i_wr_length,
    output logic                                  o_cmd_valid,
    input  logic                                  i_cmd_accept,
    output logic                                  o_cmd_write,
    output logic [ID_WIDTH-1:0]                   o_cmd_id,
    output logic [ADDRESS_WIDTH-1:0]              o_cmd_addr,
    output logic [LENGTH_WIDTH-1:0]               o_cmd_length,
    input  logic                                  i_rd_done,
    input  logic                                  i_wr_done,
    output logic [$clog2(MAX_READS+1)-1:0]        o_rd_outstanding,
    output logic [$clog2(MAX_WRITES+1)-1:0]       o_wr_outstanding
);
    localparam int RCW  = $clog2(MAX_READS + 1);
    localparam int WCW  = $clog2(MAX_WRITES + 1);
    localparam int MAXW = (READ_WEIGHT > WRITE_WEIGHT) ? READ_WEIGHT : WRITE_WEIGHT;
    localparam int GW   = $clog2(MAXW + 1);

    if (READ_WEIGHT < 1 || WRITE_WEIGHT < 1 || MAX_READS < 1 || MAX_WRITES < 1 || STARVE_CYCLES < 1) begin : g_param_check
        $error("pzcorebus_axi_rw_command_arbiter: weights, limits and STARVE_CYCLES must all be >= 1");
    end

    typedef struct packed {
        logic                     write;
        logic [ID_WIDTH-1:0]      id;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [LENGTH_WIDTH-1:0]  length;
    } cmd_t;

    typedef enum logic {
        PHASE_READ  = 1'b0,
        PHASE_WRITE = 1'b1
    } phase_e;

    phase_e         phase;
    phase_e         phase_next;
    logic [GW-1:0]  gcnt;
    logic [GW-1:0]  gcnt_next;
    logic [GW-1:0]  gcnt_inc;
    logic [RCW-1:0] rd_count;
    logic [WCW-1:0] wr_count;
    cmd_t           cmd_q;
    logic           free;
    logic           rd_elig;
    logic           wr_elig;
    logic           rd_grant;
    logic           wr_grant;
    logic           rd_dec;
    logic           wr_dec;

    assign free    = !o_cmd_valid || i_cmd_accept;
    assign rd_elig = i_rd_valid && (rd_count < RCW'(MAX_READS));
    assign wr_elig = i_wr_valid && (wr_count < WCW'(MAX_WRITES));

    // Reset gating keeps requesters from seeing a handshake that the register cannot capture.
    assign rd_grant = i_rst_n && free && rd_elig && (!wr_elig || phase == PHASE_READ);
    assign wr_grant = i_rst_n && free && wr_elig && (!rd_elig || phase == PHASE_WRITE);

    assign o_rd_ready = rd_grant;
    assign o_wr_ready = wr_grant;

`ifdef PZCOREBUS_RW_ARBITER_STARVATION_EN
    localparam int SW = $clog2(STARVE_CYCLES + 1);
    logic [SW-1:0] rd_starve_cnt;
    logic [SW-1:0] wr_starve_cnt;
    logic          rd_starve;
    logic          wr_starve;

    // Asserted on the cycle the timer reaches the limit, and kept while the side stays unserved.
    assign rd_starve = rd_elig && !rd_grant && (rd_starve_cnt >= SW'(STARVE_CYCLES - 1));
    assign wr_starve = wr_elig && !wr_grant && (wr_starve_cnt >= SW'(STARVE_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_starve_cnt <= '0;
            wr_starve_cnt <= '0;
        end else begin
            if (rd_grant)                                             rd_starve_cnt <= '0;
            else if (rd_elig && rd_starve_cnt != SW'(STARVE_CYCLES)) rd_starve_cnt <= rd_starve_cnt + SW'(1);
            if (wr_grant)                                             wr_starve_cnt <= '0;
            else if (wr_elig && wr_starve_cnt != SW'(STARVE_CYCLES)) wr_starve_cnt <= wr_starve_cnt + SW'(1);
        end
    end
`endif

    // A grant on the non-current side starts a fresh run on that side at count 1.
    always_comb begin
        phase_next = phase;
        gcnt_next  = gcnt;
        gcnt_inc   = '0;
        if (rd_grant) begin
            gcnt_inc = ((phase == PHASE_READ) ? gcnt : '0) + GW'(1);
            if (gcnt_inc == GW'(READ_WEIGHT)) begin
                phase_next = PHASE_WRITE;
                gcnt_next  = '0;
            end else begin
                phase_next = PHASE_READ;
                gcnt_next  = gcnt_inc;
            end
        end else if (wr_grant) begin
            gcnt_inc = ((phase == PHASE_WRITE) ? gcnt : '0) + GW'(1);
            if (gcnt_inc == GW'(WRITE_WEIGHT)) begin
                phase_next = PHASE_READ;
                gcnt_next  = '0;
            end else begin
                phase_next = PHASE_WRITE;
                gcnt_next  = gcnt_inc;
            end
        end
`ifdef PZCOREBUS_RW_ARBITER_STARVATION_EN
        if (rd_starve) begin
            phase_next = PHASE_READ;
            gcnt_next  = '0;
        end else if (wr_starve) begin
            phase_next = PHASE_WRITE;
            gcnt_next  = '0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase <= PHASE_READ;
            gcnt  <= '0;
        end else begin
            phase <= phase_next;
            gcnt  <= gcnt_next;
        end
    end

    assign rd_dec = i_rd_done && (rd_count != '0);
    assign wr_dec = i_wr_done && (wr_count != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_grant && !rd_dec)      rd_count <= rd_count + RCW'(1);
            else if (!rd_grant && rd_dec) rd_count <= rd_count - RCW'(1);
            if (wr_grant && !wr_dec)      wr_count <= wr_count + WCW'(1);
            else if (!wr_grant && wr_dec) wr_count <= wr_count - WCW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cmd_valid <= 1'b0;
            cmd_q       <= '0;
        end else if (rd_grant) begin
            o_cmd_valid <= 1'b1;
            cmd_q       <= '{write: 1'b0, id: i_rd_id, addr: i_rd_addr, length: i_rd_length};
        end else if (wr_grant) begin
            o_cmd_valid <= 1'b1;
            cmd_q       <= '{write: 1'b1, id: i_wr_id, addr: i_wr_addr, length: i_wr_length};
        end else if (i_cmd_accept) begin
            o_cmd_valid <= 1'b0;
        end
    end

    assign o_cmd_write      = cmd_q.write;
    assign o_cmd_id         = cmd_q.id;
    assign o_cmd_addr       = cmd_q.addr;
    assign o_cmd_length     = cmd_q.length;
    assign o_rd_outstanding = rd_count;
    assign o_wr_outstanding = wr_count;

    // A completion with nothing outstanding is an upstream protocol error; it is dropped and flagged.
    rd_done_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_rd_done && rd_count == '0))
        else $warning("rd_done received with no outstanding read");
    wr_done_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_wr_done && wr_count == '0))
        else $warning("wr_done received with no outstanding write");

endmodule

// File: tb/tb_pzcorebus_axi_rw_command_arbiter.sv
// Directed scoreboard bench for pzcorebus_axi_rw_command_arbiter (MAX_READS=2, weights 4/2).
module tb_pzcorebus_axi_rw_command_arbiter;
    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int LW  = 8;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_rd_valid, o_rd_ready, i_wr_valid, o_wr_ready;
    logic [IDW-1:0]  i_rd_id, i_wr_id, o_cmd_id;
    logic [AW-1:0]   i_rd_addr, i_wr_addr, o_cmd_addr;
    logic [LW-1:0]   i_rd_length, i_wr_length, o_cmd_length;
    logic            o_cmd_valid, i_cmd_accept, o_cmd_write;
    logic            i_rd_done, i_wr_done;
    logic [1:0]      o_rd_outstanding;
    logic [3:0]      o_wr_outstanding;

    always #5 i_clk = ~i_clk;

    pzcorebus_axi_rw_command_arbiter #(
        .ID_WIDTH(IDW), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW),
        .READ_WEIGHT(4), .WRITE_WEIGHT(2), .MAX_READS(2), .MAX_WRITES(8), .STARVE_CYCLES(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
        .i_rd_id(i_rd_id), .i_rd_addr(i_rd_addr), .i_rd_length(i_rd_length),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .i_wr_id(i_wr_id), .i_wr_addr(i_wr_addr), .i_wr_length(i_wr_length),
        .o_cmd_valid(o_cmd_valid), .i_cmd_accept(i_cmd_accept), .o_cmd_write(o_cmd_write),
        .o_cmd_id(o_cmd_id), .o_cmd_addr(o_cmd_addr), .o_cmd_length(o_cmd_length),
        .i_rd_done(i_rd_done), .i_wr_done(i_wr_done),
        .o_rd_outstanding(o_rd_outstanding), .o_wr_outstanding(o_wr_outstanding)
    );

    int          tests = 0;
    int          failed = 0;
    logic [48:0] sb[$];
    int          rd_sent = 0, wr_sent = 0, rd_goal = 0, wr_goal = 0, rd_after = 0;
    int          mrd = 0, mwr = 0, base_r, base_w;
    bit          auto_done, rd_done_pulse, wr_done_pulse, stall_chk, valid_chk;

    function automatic logic [48:0] rd_cmd(int k);
        return {1'b0, 8'(8'h10 + k), 32'(32'h1000_0000 + k * 64), 8'(k + 1)};
    endfunction

    function automatic logic [48:0] wr_cmd(int k);
        return {1'b1, 8'(8'h80 + k), 32'(32'h2000_0000 + k * 64), 8'(8'hF0 ^ k)};
    endfunction

    function automatic logic [48:0] obs_cmd();
        return {o_cmd_write, o_cmd_id, o_cmd_addr, o_cmd_length};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [48:0] rc, wc;
        rc = rd_cmd(rd_sent);
        wc = wr_cmd(wr_sent);
        i_rd_valid  = (rd_sent < rd_goal) && (wr_sent >= rd_after);
        i_rd_id     = rc[47:40];
        i_rd_addr   = rc[39:8];
        i_rd_length = rc[7:0];
        i_wr_valid  = (wr_sent < wr_goal);
        i_wr_id     = wc[47:40];
        i_wr_addr   = wc[39:8];
        i_wr_length = wc[7:0];
        i_rd_done   = rd_done_pulse || (auto_done && mrd > 0);
        i_wr_done   = wr_done_pulse || (auto_done && mwr > 0);
    endtask

    // One clock: sample/score the current cycle, advance the edge, update requesters and drive.
    task automatic tick();
        bit          rd_g, wr_g, rd_dec, wr_dec;
        logic [48:0] e;
        #1;
        if (o_cmd_valid && i_cmd_accept) begin
            tests++;
            assert (sb.size() != 0)
            else begin
                failed++;
                $error("FAIL sb_underflow: observed cmd %h expected no command", obs_cmd());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("cmd_order", obs_cmd(), e);
            end
        end
        if (stall_chk && o_cmd_valid && !i_cmd_accept && sb.size() != 0) begin
            chk("hold_payload", obs_cmd(), sb[0]);
            chk("hold_rd_ready", o_rd_ready, 0);
            chk("hold_wr_ready", o_wr_ready, 0);
        end
        if (valid_chk) chk("stream_valid", o_cmd_valid, 1);
        chk("ready_exclusive", o_rd_ready & o_wr_ready, 0);
        rd_g = o_rd_ready;
        wr_g = o_wr_ready;
        @(posedge i_clk);
        #1;
        rd_dec  = i_rd_done && mrd > 0;
        wr_dec  = i_wr_done && mwr > 0;
        rd_sent = rd_sent + int'(rd_g);
        wr_sent = wr_sent + int'(wr_g);
        mrd     = mrd + int'(rd_g) - int'(rd_dec);
        mwr     = mwr + int'(wr_g) - int'(wr_dec);
        chk("rd_outstanding", o_rd_outstanding, mrd);
        chk("wr_outstanding", o_wr_outstanding, mwr);
        rd_done_pulse = 0;
        wr_done_pulse = 0;
        drive();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        sb.delete();
        mrd = 0; mwr = 0;
        rd_goal = rd_sent; wr_goal = wr_sent; rd_after = 0;
        auto_done = 0; rd_done_pulse = 0; wr_done_pulse = 0; stall_chk = 0; valid_chk = 0;
        i_cmd_accept = 1'b1;
        drive();
        repeat (2) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Reset state
        i_cmd_accept = 1'b1;
        drive();
        #3;
        chk("reset_valid", o_cmd_valid, 0);
        chk("reset_payload", obs_cmd(), 0);
        chk("reset_rd_cnt", o_rd_outstanding, 0);
        chk("reset_wr_cnt", o_wr_outstanding, 0);
        do_reset();

        // Both streams saturated, weights 4/2
        base_r = rd_sent; base_w = wr_sent;
        rd_goal = base_r + 8; wr_goal = base_w + 4; auto_done = 1;
        for (int k = 0; k < 4; k++) sb.push_back(rd_cmd(base_r + k));
        for (int k = 0; k < 2; k++) sb.push_back(wr_cmd(base_w + k));
        for (int k = 4; k < 8; k++) sb.push_back(rd_cmd(base_r + k));
        for (int k = 2; k < 4; k++) sb.push_back(wr_cmd(base_w + k));
        drive();
        for (int c = 0; c < 13; c++) begin
            valid_chk = (c >= 1);
            tick();
        end
        valid_chk = 0;
        chk("t1_sb_empty", sb.size(), 0);

        // Writes only, a read joins after three write grants
        do_reset();
        base_r = rd_sent; base_w = wr_sent;
        wr_goal = base_w + 6; rd_goal = base_r + 2; rd_after = base_w + 3; auto_done = 1;
        for (int k = 0; k < 4; k++) sb.push_back(wr_cmd(base_w + k));
        sb.push_back(rd_cmd(base_r));
        sb.push_back(rd_cmd(base_r + 1));
        sb.push_back(wr_cmd(base_w + 4));
        sb.push_back(wr_cmd(base_w + 5));
        drive();
        repeat (10) tick();
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_rd_count", rd_sent - base_r, 2);
        chk("t2_wr_count", wr_sent - base_w, 6);

        // Read outstanding limit
        do_reset();
        base_r = rd_sent;
        rd_goal = base_r + 5;
        for (int k = 0; k < 3; k++) sb.push_back(rd_cmd(base_r + k));
        drive();
        repeat (5) tick();
        #1;
        chk("t3_limit_ready", o_rd_ready, 0);
        chk("t3_limit_cnt", o_rd_outstanding, 2);
        chk("t3_limit_grants", rd_sent - base_r, 2);
        rd_done_pulse = 1;
        drive();
        repeat (4) tick();
        chk("t3_after_done_grants", rd_sent - base_r, 3);
        chk("t3_sb_empty", sb.size(), 0);

        // Downstream stall then release
        do_reset();
        base_r = rd_sent;
        stall_chk = 1; i_cmd_accept = 1'b0; rd_goal = base_r + 2;
        sb.push_back(rd_cmd(base_r));
        sb.push_back(rd_cmd(base_r + 1));
        drive();
        repeat (6) tick();
        chk("t4_stall_grants", rd_sent - base_r, 1);
        i_cmd_accept = 1'b1;
        drive();
        tick();
        chk("t4_b2b_grant", rd_sent - base_r, 2);
        chk("t4_b2b_valid", o_cmd_valid, 1);
        tick();
        stall_chk = 0;
        chk("t4_sb_empty", sb.size(), 0);

        // Simultaneous grant and done, done at zero
        do_reset();
        base_w = wr_sent;
        wr_goal = base_w + 3;
        for (int k = 0; k < 4; k++) sb.push_back(wr_cmd(base_w + k));
        drive();
        repeat (3) tick();
        #1;
        chk("t5_wr_cnt_3", o_wr_outstanding, 3);
        wr_goal = base_w + 4; wr_done_pulse = 1;
        drive();
        tick();
        chk("t5_grant_done_cnt", o_wr_outstanding, 3);
        chk("t5_grant_taken", wr_sent - base_w, 4);
        rd_done_pulse = 1;
        drive();
        tick();
        chk("t5_rd_done_at_zero", o_rd_outstanding, 0);
        tick();
        chk("t5_sb_empty", sb.size(), 0);

        // Asynchronous reset with a command pending
        i_cmd_accept = 1'b0;
        wr_goal = wr_sent + 1;
        sb.push_back(wr_cmd(wr_sent));
        drive();
        tick();
        chk("t6_pending_valid", o_cmd_valid, 1);
        rd_goal = rd_sent + 1; wr_goal = wr_sent + 1;
        drive();
        #1 i_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", o_cmd_valid, 0);
        chk("t6_rst_payload", obs_cmd(), 0);
        chk("t6_rst_rd_cnt", o_rd_outstanding, 0);
        chk("t6_rst_wr_cnt", o_wr_outstanding, 0);
        chk("t6_rst_rd_ready", o_rd_ready, 0);
        chk("t6_rst_wr_ready", o_wr_ready, 0);
        sb.delete();
        mrd = 0; mwr = 0;
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        i_cmd_accept = 1'b1;
        sb.push_back(rd_cmd(rd_sent));
        sb.push_back(wr_cmd(wr_sent));
        drive();
        repeat (4) tick();
        chk("t6_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
